writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/mips_pkg.sv | 25 ++
 rtl/writeback_stage_if.sv | 41 ++++
 rtl/load_align.sv | 40 ++++
 rtl/writeback_stage.sv | 66 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths and load-kind encoding for the MIPS pipeline slice.
package mips_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // Load kinds carried from decode down to writeback.
    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_t;

    // Replicate the top bit of a byte or halfword across the upper bits.
    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
        return {{(DATA_W-8){b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
        return {{(DATA_W-16){h[15]}}, h};
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB bundle: MEM-side request fields, pipeline control and WB results.
interface writeback_stage_if
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
) ();

    logic                In_Valid;
    logic                Stall;
    logic                Flush;
    logic [REG_W-1:0]    In_RD;
    logic                In_RegWrite;
    logic                In_MemToReg;
    logic                In_Link;
    logic [2:0]          In_LoadType;
    logic [1:0]          In_ByteOffset;
    logic [DATA_W-1:0]   In_ALUResult;
    logic [DATA_W-1:0]   In_MemData;
    logic [DATA_W-1:0]   In_PCPlus4;

    logic [REG_W-1:0]    RD;
    logic [DATA_W-1:0]   WriteData;
    logic                RegWrite;
    logic                WB_Valid;
    logic [RETIRE_W-1:0] RetireCount;

    // Upstream pipeline / control side.
    modport master (
        output In_Valid, Stall, Flush, In_RD, In_RegWrite, In_MemToReg, In_Link,
               In_LoadType, In_ByteOffset, In_ALUResult, In_MemData, In_PCPlus4,
        input  RD, WriteData, RegWrite, WB_Valid, RetireCount
    );

    // Writeback stage side.
    modport slave (
        input  In_Valid, Stall, Flush, In_RD, In_RegWrite, In_MemToReg, In_Link,
               In_LoadType, In_ByteOffset, In_ALUResult, In_MemData, In_PCPlus4,
        output RD, WriteData, RegWrite, WB_Valid, RetireCount
    );

endinterface

// File: rtl/load_align.sv
// Little-endian lane extraction and sign/zero extension of a loaded word.
module load_align
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] MemData,
    input  logic [2:0]        LoadType,
    input  logic [1:0]        ByteOffset,
    output logic [DATA_W-1:0] ExtData
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Split the word into byte and halfword lanes, lane 0 at the low end.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign byte_lane[gi] = MemData[8*gi +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        assign half_lane[gi] = MemData[16*gi +: 16];
    end

    // Halfword loads only look at the upper offset bit.
    assign sel_byte = byte_lane[ByteOffset];
    assign sel_half = half_lane[ByteOffset[1]];

    // Extend the selected lane; unknown codes fall back to a full word.
    always_comb begin
        ExtData = MemData;
        case (LoadType)
            LT_LB:   ExtData = sext8(sel_byte);
            LT_LBU:  ExtData = {{(DATA_W-8){1'b0}}, sel_byte};
            LT_LH:   ExtData = sext16(sel_half);
            LT_LHU:  ExtData = {{(DATA_W-16){1'b0}}, sel_half};
            default: ExtData = MemData;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback data select and retire counter.
module writeback_stage
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    writeback_stage_if.slave  bus
);

    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   write_data_next;
    logic                reg_write_next;

    logic [REG_W-1:0]    rd_reg;
    logic [DATA_W-1:0]   write_data_reg;
    logic                reg_write_reg;
    logic                wb_valid_reg;
    logic [RETIRE_W-1:0] retire_count_reg;

    load_align u_load_align (
        .MemData    (bus.In_MemData),
        .LoadType   (bus.In_LoadType),
        .ByteOffset (bus.In_ByteOffset),
        .ExtData    (load_data)
    );

    // Writeback data: link address beats load data beats ALU result; $zero never written.
    always_comb begin
        write_data_next = bus.In_ALUResult;
        if (bus.In_Link)
            write_data_next = bus.In_PCPlus4 + 32'd4;
        else if (bus.In_MemToReg)
            write_data_next = load_data;
        reg_write_next = bus.In_Valid & bus.In_RegWrite & (bus.In_RD != '0);
    end

    // Pipeline register: reset, then flush (bubble, keep data), then stall (hold), else capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_reg           <= '0;
            write_data_reg   <= '0;
            reg_write_reg    <= 1'b0;
            wb_valid_reg     <= 1'b0;
            retire_count_reg <= '0;
        end else if (bus.Flush) begin
            reg_write_reg    <= 1'b0;
            wb_valid_reg     <= 1'b0;
        end else if (!bus.Stall) begin
            rd_reg           <= bus.In_RD;
            write_data_reg   <= write_data_next;
            reg_write_reg    <= reg_write_next;
            wb_valid_reg     <= bus.In_Valid;
            if (bus.In_Valid)
                retire_count_reg <= retire_count_reg + RETIRE_W'(1);
        end
    end

    assign bus.RD          = rd_reg;
    assign bus.WriteData   = write_data_reg;
    assign bus.RegWrite    = reg_write_reg;
    assign bus.WB_Valid    = wb_valid_reg;
    assign bus.RetireCount = retire_count_reg;

endmodule
